// File: rtl/spike_train_generator.sv
// Rate-coded spike transmitter: spreads min(N,T) single-cycle spikes evenly across
// a T-cycle window using a phase accumulator, after clearing the downstream accumulator.
module spike_train_generator #(
  parameter int DATA_WIDTH   = 16,
  parameter int WINDOW_WIDTH = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    count_valid,
  output logic                    count_ready,
  input  logic [DATA_WIDTH-1:0]   spike_count,
  input  logic [WINDOW_WIDTH-1:0] window_length,
  input  logic                    abort,
  output logic                    spike,
  output logic                    reset_accumulation,
  output logic                    busy,
  output logic                    done,
  output logic [DATA_WIDTH-1:0]   spikes_sent
);

  localparam int CW = (DATA_WIDTH > WINDOW_WIDTH) ? DATA_WIDTH : WINDOW_WIDTH;

  typedef enum logic [1:0] {IDLE, CLEAR, EMIT, DONE} state_t;

  state_t                  state;
  logic [WINDOW_WIDTH-1:0] t_len;
  logic [WINDOW_WIDTH-1:0] n_eff;
  logic [WINDOW_WIDTH-1:0] acc;
  logic [WINDOW_WIDTH-1:0] idx;

  logic [CW-1:0]           n_wide;
  logic [CW-1:0]           t_wide;
  logic [WINDOW_WIDTH-1:0] n_clamped;
  logic [WINDOW_WIDTH:0]   sum;
  logic                    fire;

  // The one-bit-wider sum cannot overflow since acc < T and n_eff <= T.
  always_comb begin
    n_wide    = CW'(spike_count);
    t_wide    = CW'(window_length);
    n_clamped = (n_wide < t_wide) ? WINDOW_WIDTH'(n_wide) : window_length;
    sum       = {1'b0, acc} + {1'b0, n_eff};
    fire      = (sum >= {1'b0, t_len});
  end

  assign count_ready = (state == IDLE) && !rst;
  assign busy        = (state != IDLE);

  // Spike for the upcoming EMIT index is decided one edge early so it leaves a register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state              <= IDLE;
      t_len              <= '0;
      n_eff              <= '0;
      acc                <= '0;
      idx                <= '0;
      spikes_sent        <= '0;
      spike              <= 1'b0;
      reset_accumulation <= 1'b0;
      done               <= 1'b0;
    end else begin
      spike              <= 1'b0;
      reset_accumulation <= 1'b0;
      done               <= 1'b0;
      case (state)
        IDLE: begin
          if (count_valid) begin
            t_len              <= window_length;
            n_eff              <= n_clamped;
            acc                <= '0;
            idx                <= '0;
            spikes_sent        <= '0;
            reset_accumulation <= 1'b1;
            state              <= CLEAR;
          end
        end
        CLEAR: begin
          if (abort) begin
            state <= IDLE;
          end else if (t_len == '0) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            state <= EMIT;
            spike <= fire;
            acc   <= fire ? WINDOW_WIDTH'(sum - {1'b0, t_len}) : WINDOW_WIDTH'(sum);
            if (fire) spikes_sent <= spikes_sent + DATA_WIDTH'(1);
          end
        end
        EMIT: begin
          if (abort) begin
            state <= IDLE;
          end else if (idx == t_len - WINDOW_WIDTH'(1)) begin
            done  <= 1'b1;
            state <= DONE;
          end else begin
            idx   <= idx + WINDOW_WIDTH'(1);
            spike <= fire;
            acc   <= fire ? WINDOW_WIDTH'(sum - {1'b0, t_len}) : WINDOW_WIDTH'(sum);
            if (fire) spikes_sent <= spikes_sent + DATA_WIDTH'(1);
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_train_generator.sv
// Directed and back-to-back checks of spike_train_generator, with a model of the
// attached accumulator element driven by spike/reset_accumulation.
module tb_spike_train_generator;

  logic        clk = 1'b0;
  logic        rst;
  logic        count_valid;
  logic        count_ready;
  logic [15:0] spike_count;
  logic [15:0] window_length;
  logic        abort;
  logic        spike;
  logic        reset_accumulation;
  logic        busy;
  logic        done;
  logic [15:0] spikes_sent;

  int total = 0;
  int bad   = 0;

  logic [15:0] acc_model = '0;

  always #5 clk = ~clk;

  spike_train_generator #(.DATA_WIDTH(16), .WINDOW_WIDTH(16)) dut (
    .clk                (clk),
    .rst                (rst),
    .count_valid        (count_valid),
    .count_ready        (count_ready),
    .spike_count        (spike_count),
    .window_length      (window_length),
    .abort              (abort),
    .spike              (spike),
    .reset_accumulation (reset_accumulation),
    .busy               (busy),
    .done               (done),
    .spikes_sent        (spikes_sent)
  );

  // Downstream accumulator element
  always @(posedge clk) begin
    if (reset_accumulation) acc_model <= '0;
    else if (spike) acc_model <= acc_model + 16'd1;
  end

  task automatic test_reset();
    rst = 1'b1; count_valid = 1'b1; abort = 1'b0; spike_count = 16'd3; window_length = 16'd4;
    repeat (2) @(posedge clk);
    @(negedge clk);
    total++;
    if (count_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_ready: got=%b expected=0", count_ready);
    end
    total++;
    if ({spike, reset_accumulation, done, busy} !== 4'b0000) begin
      bad++; $display("[TB] FAIL reset_outputs: got=%b expected=0000", {spike, reset_accumulation, done, busy});
    end
    total++;
    if (spikes_sent !== 16'd0) begin
      bad++; $display("[TB] FAIL reset_sent: got=%0d expected=0", spikes_sent);
    end
    count_valid = 1'b0;
    rst = 1'b0;
    @(posedge clk);
    @(negedge clk);
    total++;
    if (count_ready !== 1'b1 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL reset_release: got ready=%b busy=%b expected ready=1 busy=0", count_ready, busy);
    end
  endtask

  task automatic test_window(input string name, input logic [15:0] n, input logic [15:0] t,
                             input logic [63:0] exp_mask, input logic [15:0] exp_sent);
    @(negedge clk);
    total++;
    if (count_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL %s_ready_before: got=%b expected=1", name, count_ready);
    end
    spike_count = n; window_length = t; count_valid = 1'b1;
    @(posedge clk);
    #1 count_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({reset_accumulation, busy, spike, done, count_ready} !== 5'b11000) begin
      bad++; $display("[TB] FAIL %s_clear: got=%b expected=11000", name,
                      {reset_accumulation, busy, spike, done, count_ready});
    end
    for (int i = 0; i < int'(t); i++) begin
      @(negedge clk);
      total++;
      if (spike !== exp_mask[i] || done !== 1'b0) begin
        bad++; $display("[TB] FAIL %s_emit%0d: got spike=%b done=%b expected spike=%b done=0",
                        name, i, spike, done, exp_mask[i]);
      end
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || spike !== 1'b0 || count_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL %s_done: got done=%b spike=%b ready=%b expected 1 0 0", name, done, spike, count_ready);
    end
    total++;
    if (spikes_sent !== exp_sent) begin
      bad++; $display("[TB] FAIL %s_sent: got=%0d expected=%0d", name, spikes_sent, exp_sent);
    end
    total++;
    if (acc_model !== exp_sent) begin
      bad++; $display("[TB] FAIL %s_accum: got=%0d expected=%0d", name, acc_model, exp_sent);
    end
    @(negedge clk);
    total++;
    if (count_ready !== 1'b1 || done !== 1'b0 || busy !== 1'b0) begin
      bad++; $display("[TB] FAIL %s_idle: got ready=%b done=%b busy=%b expected 1 0 0", name, count_ready, done, busy);
    end
    total++;
    if (spikes_sent !== exp_sent) begin
      bad++; $display("[TB] FAIL %s_sent_hold: got=%0d expected=%0d", name, spikes_sent, exp_sent);
    end
  endtask

  task automatic test_abort();
    logic [15:0] exp_mask;
    bit          late_bad;
    exp_mask = 16'h8888;
    @(negedge clk);
    spike_count = 16'd4; window_length = 16'd16; count_valid = 1'b1;
    @(posedge clk);
    #1 count_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (spike !== exp_mask[i]) begin
        bad++; $display("[TB] FAIL abort_emit%0d: got=%b expected=%b", i, spike, exp_mask[i]);
      end
    end
    abort = 1'b1;
    @(posedge clk);
    #1 abort = 1'b0;
    @(negedge clk);
    total++;
    if ({spike, done, busy, count_ready} !== 4'b0001) begin
      bad++; $display("[TB] FAIL abort_after: got=%b expected=0001", {spike, done, busy, count_ready});
    end
    total++;
    if (spikes_sent !== 16'd2) begin
      bad++; $display("[TB] FAIL abort_sent: got=%0d expected=2", spikes_sent);
    end
    late_bad = 1'b0;
    repeat (4) begin
      @(negedge clk);
      if (done !== 1'b0 || spike !== 1'b0) late_bad = 1'b1;
    end
    total++;
    if (late_bad) begin
      bad++; $display("[TB] FAIL abort_quiet: got activity=1 expected=0");
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] exp_mask;
    exp_mask = 16'h8888;
    @(negedge clk);
    spike_count = 16'd4; window_length = 16'd16; count_valid = 1'b1;
    @(posedge clk);
    #1 count_valid = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      total++;
      if (spike !== exp_mask[i]) begin
        bad++; $display("[TB] FAIL rstmid_emit%0d: got=%b expected=%b", i, spike, exp_mask[i]);
      end
    end
    rst = 1'b1;
    count_valid = 1'b1;
    #1;
    total++;
    if (count_ready !== 1'b0) begin
      bad++; $display("[TB] FAIL rstmid_ready_low: got=%b expected=0", count_ready);
    end
    @(posedge clk);
    #1 rst = 1'b0; count_valid = 1'b0;
    @(negedge clk);
    total++;
    if ({spike, reset_accumulation, done, busy} !== 4'b0000 || spikes_sent !== 16'd0) begin
      bad++; $display("[TB] FAIL rstmid_after: got=%b sent=%0d expected=0000 sent=0",
                      {spike, reset_accumulation, done, busy}, spikes_sent);
    end
    total++;
    if (count_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL rstmid_ready: got=%b expected=1", count_ready);
    end
  endtask

  task automatic test_abort_idle();
    @(negedge clk);
    abort = 1'b1; count_valid = 1'b1; spike_count = 16'd1; window_length = 16'd1;
    @(posedge clk);
    #1 abort = 1'b0; count_valid = 1'b0;
    @(negedge clk);
    total++;
    if (reset_accumulation !== 1'b1 || busy !== 1'b1) begin
      bad++; $display("[TB] FAIL abortidle_clear: got rac=%b busy=%b expected 1 1", reset_accumulation, busy);
    end
    @(negedge clk);
    total++;
    if (spike !== 1'b1) begin
      bad++; $display("[TB] FAIL abortidle_spike: got=%b expected=1", spike);
    end
    @(negedge clk);
    total++;
    if (done !== 1'b1 || spikes_sent !== 16'd1) begin
      bad++; $display("[TB] FAIL abortidle_done: got done=%b sent=%0d expected 1 1", done, spikes_sent);
    end
    @(negedge clk);
    total++;
    if (count_ready !== 1'b1) begin
      bad++; $display("[TB] FAIL abortidle_ready: got=%b expected=1", count_ready);
    end
  endtask

  task automatic test_back_to_back();
    int   n, t, neff, win_total, pos_bad, wait_cnt;
    bit   phase_bad;
    logic exp_bit;
    @(negedge clk);
    count_valid = 1'b1;
    for (int r = 0; r < 200; r++) begin
      t = int'($urandom_range(64, 0));
      n = int'($urandom_range(80, 0));
      neff = (n < t) ? n : t;
      spike_count = 16'(n);
      window_length = 16'(t);
      wait_cnt = 0;
      while (count_ready !== 1'b1 && wait_cnt < 200) begin
        @(negedge clk);
        wait_cnt++;
      end
      if (wait_cnt == 200) begin
        bad++; $display("[TB] FAIL b2b_timeout: got ready=%b expected=1", count_ready);
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "[TB] handshake timeout");
      end
      @(posedge clk);
      phase_bad = 1'b0; pos_bad = 0; win_total = 0;
      @(negedge clk);
      if (count_ready !== 1'b0 || reset_accumulation !== 1'b1) phase_bad = 1'b1;
      for (int i = 0; i < t; i++) begin
        @(negedge clk);
        if (count_ready !== 1'b0) phase_bad = 1'b1;
        exp_bit = (((i + 1) * neff) / t > (i * neff) / t) ? 1'b1 : 1'b0;
        if (spike !== exp_bit) pos_bad++;
        if (spike === 1'b1) win_total++;
      end
      @(negedge clk);
      total++;
      if (done !== 1'b1 || count_ready !== 1'b0 || phase_bad) begin
        bad++; $display("[TB] FAIL b2b_phase r=%0d: got done=%b ready=%b phase_err=%b expected 1 0 0",
                        r, done, count_ready, phase_bad);
      end
      total++;
      if (spikes_sent !== 16'(neff) || win_total != neff) begin
        bad++; $display("[TB] FAIL b2b_count r=%0d N=%0d T=%0d: got sent=%0d seen=%0d expected=%0d",
                        r, n, t, spikes_sent, win_total, neff);
      end
      total++;
      if (pos_bad != 0) begin
        bad++; $display("[TB] FAIL b2b_positions r=%0d N=%0d T=%0d: got wrong=%0d expected=0", r, n, t, pos_bad);
      end
      @(negedge clk);
      total++;
      if (count_ready !== 1'b1) begin
        bad++; $display("[TB] FAIL b2b_period r=%0d: got ready=%b expected=1 at T+3", r, count_ready);
      end
      if (r == 199) count_valid = 1'b0;
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    test_reset();
    test_window("n3_t8",   16'd3,     16'd8, 64'b1010_0100, 16'd3);
    test_window("n5_t5",   16'd5,     16'd5, 64'h1F,        16'd5);
    test_window("n10_t4",  16'd10,    16'd4, 64'hF,         16'd4);
    test_window("n0_t6",   16'd0,     16'd6, 64'h0,         16'd0);
    test_window("n7_t0",   16'd7,     16'd0, 64'h0,         16'd0);
    test_window("n1_t3",   16'd1,     16'd3, 64'b100,       16'd1);
    test_window("nmax_t2", 16'hFFFF,  16'd2, 64'b11,        16'd2);
    test_abort();
    test_reset_mid();
    test_abort_idle();
    test_back_to_back();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spike_train_generator.md
# spike_train_generator

Rate-coded spike transmitter: accepts a spike count N and a window length T over a valid/ready handshake, then emits exactly min(N,T) single-cycle spikes spread evenly across a T-cycle window. It is the driving end of the spike/accumulator interface. `spike` and `reset_accumulation` connect directly to a downstream accumulator element, so the accumulator reads back min(N,T) at the end of each window. It sits between the weight/activation source and the neuron/accumulator array in test and inference datapaths.

## Interface
- DATA_WIDTH, 16, width of spike count and of `spikes_sent`
- WINDOW_WIDTH, 16, width of window length T
- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- count_valid  in  1  request valid
- count_ready  out  1  block can accept a request
- spike_count  in  DATA_WIDTH  requested spikes N, sampled on handshake
- window_length  in  WINDOW_WIDTH  window cycles T, sampled on handshake
- abort  in  1  synchronous cancel of the current request
- spike  out  1  spike output, to the accumulator `spike` input
- reset_accumulation  out  1  one-cycle clear pulse, to the accumulator
- busy  out  1  high whenever state != IDLE
- done  out  1  one-cycle pulse at window completion
- spikes_sent  out  DATA_WIDTH  spikes emitted for the current/last request

## Operation
- States: IDLE, CLEAR, EMIT, DONE.
- IDLE:
  - count_ready=1.
  - Handshake = count_valid & count_ready at a rising edge.
  - On handshake: latch T, and latch N_eff = min(N,T), compared at max(DATA_WIDTH,WINDOW_WIDTH) bits.
  - On handshake: clear phase accumulator `acc` and `spikes_sent`, then go to CLEAR.
- CLEAR:
  - Exactly one cycle, reset_accumulation=1, spike=0.
  - Go to DONE if T==0, else go to EMIT.
- EMIT:
  - Lasts T cycles, indexed i = 0..T-1, using a WINDOW_WIDTH cycle counter.
  - Each cycle: sum = acc + N_eff, computed at WINDOW_WIDTH+1 bits, so there is no overflow because acc < T and N_eff ≤ T.
  - If sum ≥ T: spike=1, acc ← sum − T, spikes_sent += 1. Otherwise spike=0 and acc ← sum.
  - Equivalent rule: spike at index i iff floor((i+1)·N_eff/T) > floor(i·N_eff/T).
  - After index T-1, go to DONE.
- DONE: done=1 for one cycle, spike=0, count_ready=0, then go to IDLE.
- N_eff=0: no spikes. N_eff=T: spike on every EMIT cycle. N>T: clamped, with no error flag.
- abort:
  - In CLEAR, EMIT or DONE, the next state is IDLE.
  - No done pulse; spike=0 from the next cycle.
  - spikes_sent holds the partial count.
  - abort in IDLE has no effect and does not block a simultaneous handshake.
- rst:
  - Has priority over abort and handshake.
  - Next state is IDLE. acc, counters, spikes_sent and all output registers are set to 0.
  - count_ready reads 0 while rst is high. count_valid is ignored in that cycle.
- Outputs are driven from registers or a state decode only. There is no combinational path from inputs to outputs, except count_ready, which depends on rst.

## Timing
- Reset values: spike=0, reset_accumulation=0, done=0, busy=0, spikes_sent=0. count_ready=0 during rst, and 1 in the first cycle after rst is released.
- Handshake at edge k:
  - Cycle k+1: CLEAR (reset_accumulation=1, busy=1).
  - Cycles k+2 .. k+1+T: EMIT.
  - Cycle k+2+T: DONE (done=1).
  - Cycle k+3+T: IDLE (count_ready=1).
- T==0: CLEAR at k+1, DONE at k+2, IDLE at k+3. No spikes are emitted.
- Request-to-request period is T+3 cycles. count_ready is low from k+1 through k+2+T.
- spikes_sent is final, equal to N_eff, in the DONE cycle and holds until the next handshake.
- A downstream accumulator sampling at the DONE cycle holds exactly N_eff, because the clear pulse precedes the first spike by one cycle.

## Test plan
- N=3, T=8:
  - Spikes at EMIT indices 2, 5 and 7 only.
  - done at k+10; spikes_sent=3.
  - Attached accumulator element reads 3.
- N=5, T=5: spike high for all 5 EMIT cycles; done at k+7; spikes_sent=5.
- N=10, T=4 (clamp): 4 spikes on consecutive cycles; spikes_sent=4. Also N=0, T=6: no spikes, done at k+8.
- T=0 with any N: reset_accumulation pulse at k+1, done at k+2, no spike, count_ready back high at k+3.
- Mid-window disturbances, N=4, T=16:
  - abort asserted at EMIT index 9: no done pulse, spike=0 afterwards, spikes_sent=2, count_ready=1 on the next cycle.
  - Repeat with rst at EMIT index 9 instead: all outputs 0 the next cycle.
- Back-to-back with count_valid held high and random (N,T) with T ≤ 64, 200 requests:
  - Each handshake occurs T+3 cycles after the previous one.
  - Per-window spike total equals min(N,T).
  - A scoreboard checks the spike positions against the floor formula.
